// File: rtl/wb_spi_slave.sv
// wb_spi_slave: Wishbone-attached SPI slave (mode 0, MSB first, 8-bit frames).
// The external SPI pins are asynchronous. They are synchronized into clk before
// any edge detection.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   wb_adr_i[3:2]          register select: 0 RXDATA, 1 TXDATA, 2 STATUS, 3 CTRL
//   wb_dat_i / wb_dat_o    write / read data (wb_sel_i ignored)
//   wb_cyc_i, wb_stb_i,
//   wb_we_i, wb_ack_o      single-cycle registered acknowledge
//   intr                   rx_ie & rx_full, registered
//   spi_sclk, spi_mosi,
//   spi_ss_n               SPI bus from the external master
//   spi_miso, spi_miso_oe  transmit bit and its pad enable
//
// state  | meaning
// IDLE   | slave not selected, waiting for an ss_n falling edge
// SHIFT  | frame in progress, shifting on sclk edges
module wb_spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic        intr,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_ss_n,
  output logic        spi_miso,
  output logic        spi_miso_oe
);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ss_sync;
  logic r_sclk_d, r_ss_d;

  state_t      r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_rx_shift, r_tx_shift, r_rx_data, r_tx_buf;
  logic        r_rx_full, r_tx_full, r_overrun, r_reload;
  logic        r_rx_ie, r_enable;
  logic        r_ack, r_intr, r_oe;
  logic [31:0] r_dat_o;

  logic        w_sclk, w_mosi, w_ss_n;
  logic        w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
  logic        w_wb_req, w_wr, w_rd, w_rd_rx, w_wr_tx, w_wr_st, w_wr_ctrl;
  logic        w_shift, w_done, w_rx_busy, w_tx_load;
  logic [7:0]  w_rx_byte, w_tx_next;
  logic [31:0] w_rd_data;
  logic        w_unused;

  assign w_unused = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8]};

  // A disabled slave sees ss_n as permanently inactive, so clearing enable
  // mid-frame looks like a deselect and ends the frame cleanly.
  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss_n = r_ss_sync[SYNC_STAGES-1] | ~r_enable;

  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_ss_fall   = ~w_ss_n & r_ss_d;
  assign w_ss_rise   = w_ss_n & ~r_ss_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_sync   <= '1;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_ss_n};
      r_sclk_d    <= w_sclk;
      r_ss_d      <= w_ss_n;
    end
  end

  // Register side effects happen in the ack cycle; address and we are still
  // held by the master then.
  assign w_wb_req  = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr      = r_ack & wb_we_i;
  assign w_rd      = r_ack & ~wb_we_i;
  assign w_rd_rx   = w_rd & (wb_adr_i[3:2] == 2'd0);
  assign w_wr_tx   = w_wr & (wb_adr_i[3:2] == 2'd1);
  assign w_wr_st   = w_wr & (wb_adr_i[3:2] == 2'd2);
  assign w_wr_ctrl = w_wr & (wb_adr_i[3:2] == 2'd3);

  assign w_shift   = (r_state == S_SHIFT);
  assign w_done    = w_shift & ~w_ss_rise & w_sclk_rise & (r_bit_cnt == 3'd7);
  assign w_rx_byte = {r_rx_shift[6:0], w_mosi};
  // A read of RXDATA in the completion cycle frees the slot for the new byte.
  assign w_rx_busy = r_rx_full & ~w_rd_rx;
  assign w_tx_load = ((r_state == S_IDLE) & w_ss_fall) |
                     (w_shift & ~w_ss_rise & w_sclk_fall & r_reload);
  assign w_tx_next = r_tx_full ? r_tx_buf : 8'hFF;

  always_comb begin
    w_rd_data = '0;
    case (wb_adr_i[3:2])
      2'd0:    w_rd_data = {24'd0, r_rx_data};
      2'd2:    w_rd_data = {28'd0, w_shift, r_overrun, r_tx_full, r_rx_full};
      2'd3:    w_rd_data = {30'd0, r_enable, r_rx_ie};
      default: w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 8'h00;
      r_tx_shift <= 8'hFF;
      r_rx_data  <= 8'h00;
      r_tx_buf   <= 8'h00;
      r_rx_full  <= 1'b0;
      r_tx_full  <= 1'b0;
      r_overrun  <= 1'b0;
      r_reload   <= 1'b0;
      r_rx_ie    <= 1'b0;
      r_enable   <= 1'b0;
      r_ack      <= 1'b0;
      r_dat_o    <= '0;
      r_intr     <= 1'b0;
      r_oe       <= 1'b0;
    end else begin
      r_ack   <= w_wb_req;
      r_dat_o <= (w_wb_req & ~wb_we_i) ? w_rd_data : '0;
      r_intr  <= r_rx_ie & r_rx_full;

      if (w_wr_ctrl) {r_enable, r_rx_ie} <= wb_dat_i[1:0];

      case (r_state)
        S_IDLE: begin
          if (w_ss_fall) begin
            r_state   <= S_SHIFT;
            r_bit_cnt <= 3'd0;
            r_reload  <= 1'b0;
            r_oe      <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_ss_rise) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
            r_reload  <= 1'b0;
            r_oe      <= 1'b0;
          end else if (w_sclk_rise) begin
            r_rx_shift <= w_rx_byte;
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_reload <= 1'b1;
          end else if (w_sclk_fall) begin
            // First falling edge after a completed byte fetches the next byte.
            if (r_reload) r_reload <= 1'b0;
            else          r_tx_shift <= {r_tx_shift[6:0], 1'b1};
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // The load sees the pre-write buffer; a same-cycle write stays pending.
      if (w_tx_load) begin
        r_tx_shift <= w_tx_next;
        r_tx_full  <= 1'b0;
      end
      if (w_wr_tx) begin
        r_tx_buf  <= wb_dat_i[7:0];
        r_tx_full <= 1'b1;
      end

      if (w_done && !w_rx_busy) begin
        r_rx_data <= w_rx_byte;
        r_rx_full <= 1'b1;
      end else if (w_rd_rx) begin
        r_rx_full <= 1'b0;
      end

      // Setting overrun takes priority over a same-cycle clear.
      if (w_wr_st && wb_dat_i[2]) r_overrun <= 1'b0;
      if (w_done && w_rx_busy)    r_overrun <= 1'b1;
    end
  end

  assign wb_ack_o    = r_ack;
  assign wb_dat_o    = r_dat_o;
  assign intr        = r_intr;
  assign spi_miso    = r_tx_shift[7];
  assign spi_miso_oe = r_oe;

endmodule

// File: tb/tb_wb_spi_slave.sv
module tb_wb_spi_slave;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o, intr;
  logic        spi_sclk, spi_mosi, spi_ss_n, spi_miso, spi_miso_oe;
  logic        w_pad;

  always #5 clk = ~clk;

  wb_spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o), .intr(intr),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
  );

  // Undriven pad reads as 1 (pull-up).
  assign w_pad = spi_miso_oe ? spi_miso : 1'b1;

  int oe_cnt = 0;
  always @(negedge clk) if (spi_miso_oe) oe_cnt++;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0] ctrl;
    bit         wr_tx;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    bit         exp_oe;
    logic [3:0] exp_status;
    bit         exp_intr;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input bit we, input logic [1:0] a, input logic [31:0] wd,
                         output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    wb_adr_i = {28'd0, a, 2'b00};
    wb_dat_i = wd;
    wb_we_i  = we;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    n  = 0;
    rd = '0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!wb_ack_o && n < 4);
    if (!wb_ack_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL wb_ack_timeout: got no ack expected ack within 4 cycles");
    end else begin
      rd = wb_dat_o;
    end
    @(posedge clk); #1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    wb_xfer(1'b0, a, 32'd0, d);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] v);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, v, dummy);
  endtask

  task automatic ss_assert();
    spi_ss_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic ss_deassert();
    wait_clk(HALF);
    spi_ss_n = 1'b1;
    wait_clk(HALF);
  endtask

  // Mode 0 master: drive mosi while sclk is low, sample the pad on the rising edge.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      wait_clk(HALF);
      rx = {rx[6:0], w_pad};
      spi_sclk = 1'b1;
      wait_clk(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  logic [31:0] d;
  logic [7:0]  mi, m0, m1, v, mo, exp_b;
  int          oe0, nb;
  bit          m_rx_full, m_tx_full, m_ovr;
  logic [7:0]  m_rx_data, m_tx_val;

  initial begin
    vecs[0] = '{2'd3, 1'b1, 8'hA5, 8'h3C, 8'hA5, 1'b1, 4'h1, 1'b1, 8'h3C};
    vecs[1] = '{2'd3, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b1, 4'h1, 1'b1, 8'h00};
    vecs[2] = '{2'd2, 1'b1, 8'h5A, 8'hC3, 8'h5A, 1'b1, 4'h1, 1'b0, 8'hC3};
    vecs[3] = '{2'd1, 1'b1, 8'h77, 8'hFF, 8'hFF, 1'b0, 4'h2, 1'b0, 8'hC3};
    vecs[4] = '{2'd3, 1'b1, 8'h96, 8'h69, 8'h96, 1'b1, 4'h1, 1'b1, 8'h69};
    vecs[5] = '{2'd3, 1'b0, 8'h00, 8'h80, 8'hFF, 1'b1, 4'h1, 1'b1, 8'h80};

    reset = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 4'hF;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b1;
    wait_clk(4);
    chk("rst_ack", wb_ack_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_intr", intr, 0);
    chk("rst_miso", spi_miso, 1);
    chk("rst_oe", spi_miso_oe, 0);
    reset = 1'b0;
    wait_clk(2);
    wb_read(2'd2, d); chk("rst_status", d, 0);
    wb_read(2'd3, d); chk("rst_ctrl", d, 0);
    wb_read(2'd0, d); chk("rst_rxdata", d, 0);

    // Holding cyc/stb gives an ack every other cycle.
    wb_write(2'd3, 32'hFFFF_FFF3);
    @(posedge clk); #1;
    wb_adr_i = {28'd0, 2'd3, 2'b00}; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("ack_pattern_%0d", i), wb_ack_o, (i != 1));
      if (i == 0) chk("ack_rd_ctrl", wb_dat_o, 32'h3);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk); #1;
    chk("ack_drop", wb_ack_o, 0);

    for (int r = 0; r < 6; r++) begin
      wb_read(2'd0, d);
      wb_write(2'd2, 32'h4);
      wb_write(2'd3, {30'd0, vecs[r].ctrl});
      if (vecs[r].wr_tx) wb_write(2'd1, {24'hABCDE1, vecs[r].tx});
      oe0 = oe_cnt;
      ss_assert();
      spi_bits(vecs[r].mosi, 8, mi);
      ss_deassert();
      chk($sformatf("vec%0d_miso", r), mi, vecs[r].exp_miso);
      chk($sformatf("vec%0d_oe", r), (oe_cnt != oe0), vecs[r].exp_oe);
      wb_read(2'd2, d); chk($sformatf("vec%0d_status", r), d, {28'd0, vecs[r].exp_status});
      chk($sformatf("vec%0d_intr", r), intr, vecs[r].exp_intr);
      wb_read(2'd0, d); chk($sformatf("vec%0d_rxdata", r), d, {24'd0, vecs[r].exp_rx});
    end

    // Two bytes in one frame with no read in between: second byte overruns.
    wb_read(2'd0, d);
    wb_write(2'd1, 32'hAB);
    ss_assert();
    spi_bits(8'h11, 8, m0);
    spi_bits(8'h22, 8, m1);
    ss_deassert();
    chk("b2b_miso0", m0, 8'hAB);
    chk("b2b_miso1", m1, 8'hFF);
    wb_read(2'd2, d);  chk("b2b_status", d, 32'h5);
    wb_write(2'd2, 32'h4);
    wb_read(2'd2, d);  chk("b2b_status_w1c", d, 32'h1);
    wb_read(2'd0, d);  chk("b2b_rxdata", d, 32'h11);
    wb_read(2'd2, d);  chk("b2b_status_clr", d, 32'h0);

    // Partial byte discarded, then a full byte.
    ss_assert();
    wb_read(2'd2, d);  chk("partial_busy", d, 32'h8);
    spi_bits(8'hB0, 5, mi);
    ss_deassert();
    wb_read(2'd2, d);  chk("partial_status", d, 32'h0);
    ss_assert();
    spi_bits(8'h81, 8, mi);
    ss_deassert();
    wb_read(2'd2, d);  chk("partial_full_status", d, 32'h1);
    wb_read(2'd0, d);  chk("partial_rxdata", d, 32'h81);
    ss_assert();
    spi_bits(8'h42, 8, mi);
    ss_deassert();
    chk("pre_reset_intr", intr, 1);

    // Reset in the middle of a frame.
    ss_assert();
    spi_bits(8'hF0, 4, mi);
    reset = 1'b1;
    wait_clk(3);
    chk("midrst_miso", spi_miso, 1);
    chk("midrst_oe", spi_miso_oe, 0);
    chk("midrst_intr", intr, 0);
    chk("midrst_ack", wb_ack_o, 0);
    chk("midrst_dat", wb_dat_o, 0);
    reset = 1'b0;
    spi_ss_n = 1'b1;
    wait_clk(4);
    wb_read(2'd2, d);  chk("midrst_status", d, 32'h0);
    wb_read(2'd0, d);  chk("midrst_rxdata", d, 32'h0);
    wb_write(2'd3, 32'h3);
    ss_assert();
    spi_bits(8'h5A, 8, mi);
    ss_deassert();
    chk("postrst_miso", mi, 8'hFF);
    wb_read(2'd0, d);  chk("postrst_rxdata", d, 32'h5A);

    // Random frames against a byte-level model of the buffers.
    m_rx_full = 1'b0; m_tx_full = 1'b0; m_ovr = 1'b0;
    m_rx_data = 8'h5A; m_tx_val = 8'h00;
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        v = 8'($urandom_range(0, 255));
        wb_write(2'd1, {24'd0, v});
        m_tx_full = 1'b1; m_tx_val = v;
      end
      if ($urandom_range(0, 2) == 0) begin
        wb_read(2'd0, d);
        chk($sformatf("rnd%0d_rxdata", it), d, {24'd0, m_rx_data});
        m_rx_full = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        wb_write(2'd2, 32'h4);
        m_ovr = 1'b0;
      end
      nb = $urandom_range(1, 3);
      ss_assert();
      for (int k = 0; k < nb; k++) begin
        mo = 8'($urandom_range(0, 255));
        spi_bits(mo, 8, mi);
        exp_b = m_tx_full ? m_tx_val : 8'hFF;
        m_tx_full = 1'b0;
        chk($sformatf("rnd%0d_miso%0d", it, k), mi, exp_b);
        if (m_rx_full) m_ovr = 1'b1;
        else begin
          m_rx_data = mo;
          m_rx_full = 1'b1;
        end
      end
      ss_deassert();
      wb_read(2'd2, d);
      chk($sformatf("rnd%0d_status", it), d, {29'd0, m_ovr, m_tx_full, m_rx_full});
      chk($sformatf("rnd%0d_intr", it), intr, m_rx_full);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
